// File: rtl/cpu_job_sequencer_pkg.sv
// rtl/cpu_job_sequencer_pkg.sv - shared state encoding and CPU interface constants
package cpu_job_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET_CPU = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } seq_state_t;

  localparam int          CPU_DATA_W   = 16;
  localparam int          CPU_CYC_W    = 16;
  localparam logic [15:0] CPU_IDLE_VAL = 16'h0000;

endpackage

// File: rtl/cpu_job_sequencer_stability.sv
// rtl/cpu_job_sequencer_stability.sv - counts consecutive identical non-idle CPU output samples
module result_stability_detector
  import cpu_job_sequencer_pkg::*;
#(
  parameter int                DATA_W        = CPU_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_VAL      = CPU_IDLE_VAL,
  parameter int                STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              clear,
  input  logic              enable,
  output logic              stable_hit,
  output logic [DATA_W-1:0] stable_value
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [DATA_W-1:0] prev_out;
  logic [CNT_W-1:0]  stable_cnt;
  logic [CNT_W-1:0]  cnt_next;

  always_comb begin
    cnt_next = '0;
    if (sample != IDLE_VAL) begin
      if (sample == prev_out) cnt_next = stable_cnt + 1'b1;
      else                    cnt_next = CNT_W'(1);
    end
  end

  // Hit is the look-ahead value so the FSM can capture the sample in the same cycle.
  assign stable_hit   = enable && (cnt_next == CNT_W'(STABLE_CYCLES));
  assign stable_value = sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_out   <= IDLE_VAL;
      stable_cnt <= '0;
    end else if (clear) begin
      prev_out   <= IDLE_VAL;
      stable_cnt <= '0;
    end else if (enable) begin
      prev_out   <= sample;
      stable_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/cpu_job_sequencer.sv
// rtl/cpu_job_sequencer.sv - runs the CPU as a single-operand compute engine per job
module cpu_job_sequencer
  import cpu_job_sequencer_pkg::*;
#(
  parameter int                DATA_W        = CPU_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_VAL      = CPU_IDLE_VAL,
  parameter int                RST_CYCLES    = 2,
  parameter int                STABLE_CYCLES = 4,
  parameter int                MAX_CYCLES    = 4096,
  parameter int                CYC_W         = CPU_CYC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_operand,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_timeout,
  output logic [CYC_W-1:0]  rsp_cycles,
  output logic              busy,
  output logic              cpu_reset,
  output logic [DATA_W-1:0] cpu_in,
  input  logic [DATA_W-1:0] cpu_out
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);

  seq_state_t        state;
  logic [RST_W-1:0]  rst_cnt;
  logic [CYC_W-1:0]  run_cnt;
  logic [CYC_W-1:0]  run_next;
  logic              stable_hit;
  logic [DATA_W-1:0] stable_value;

  assign run_next = run_cnt + 1'b1;

  result_stability_detector #(
    .DATA_W        (DATA_W),
    .IDLE_VAL      (IDLE_VAL),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stability (
    .clk          (clk),
    .reset        (reset),
    .sample       (cpu_out),
    .clear        (state == ST_RESET_CPU),
    .enable       (state == ST_RUN),
    .stable_hit   (stable_hit),
    .stable_value (stable_value)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      run_cnt     <= '0;
      job_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      rsp_cycles  <= '0;
      busy        <= 1'b0;
      cpu_reset   <= 1'b1;
      cpu_in      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (job_valid) begin
            cpu_in    <= job_operand;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            rst_cnt   <= '0;
            state     <= ST_RESET_CPU;
          end
        end

        ST_RESET_CPU: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            cpu_reset <= 1'b0;
            run_cnt   <= '0;
            state     <= ST_RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          run_cnt <= run_next;
          // A stable result on the final budget cycle still counts as a result.
          if (stable_hit || run_next == CYC_W'(MAX_CYCLES)) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= stable_hit ? stable_value : cpu_out;
            rsp_timeout <= !stable_hit;
            rsp_cycles  <= run_next;
            busy        <= 1'b0;
            cpu_reset   <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
